// File: rtl/stream_switch_axil_regs_if.sv
// AXI4-Lite channel bundle between a bus master and the stream-switch
// register block.
interface stream_switch_axil_regs_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic        bvalid;
   logic [1:0]  bresp;
   logic        bready;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rready;

   modport master (
      output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/stream_switch_axil_regs.sv
// AXI4-Lite control/status registers for one stream-switch element:
// ID, CTRL (enable + route), SCRATCH and a clearable packet counter.
module stream_switch_axil_regs #(
   parameter logic [31:0] ID_VALUE = 32'h5357_0001
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   stream_switch_axil_regs_if.slave   s_axil,
   input  logic                       pkt_done,
   output logic                       sw_enable,
   output logic [1:0]                 sw_route
);
   localparam logic [9:0] REG_ID      = 10'd0;
   localparam logic [9:0] REG_CTRL    = 10'd1;
   localparam logic [9:0] REG_SCRATCH = 10'd2;
   localparam logic [9:0] REG_PKT_CNT = 10'd3;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic        rdy_en_reg;
   logic        aw_held_reg;
   logic [9:0]  aw_idx_reg;
   logic        w_held_reg;
   logic [31:0] wdata_reg;
   logic        bvalid_reg;
   logic [1:0]  bresp_reg;
   logic        rvalid_reg;
   logic [31:0] rdata_reg;
   logic [1:0]  rresp_reg;
   logic [2:0]  ctrl_reg;
   logic [31:0] scratch_reg;
   logic [31:0] pkt_cnt_reg;

   logic        aw_hs;
   logic        w_hs;
   logic        ar_hs;
   logic        wr_commit;
   logic [9:0]  wr_idx;
   logic [31:0] wr_data;
   logic        wr_hit;
   logic [31:0] rd_data_next;
   logic [1:0]  rd_resp_next;
   logic        unused_addr_bits;

   // Readies come only from registered state, never from the valids.
   assign s_axil.awready = rdy_en_reg & ~aw_held_reg & ~bvalid_reg;
   assign s_axil.wready  = rdy_en_reg & ~w_held_reg & ~bvalid_reg;
   assign s_axil.arready = rdy_en_reg & ~rvalid_reg;
   assign s_axil.bvalid  = bvalid_reg;
   assign s_axil.bresp   = bresp_reg;
   assign s_axil.rvalid  = rvalid_reg;
   assign s_axil.rdata   = rdata_reg;
   assign s_axil.rresp   = rresp_reg;
   assign sw_enable      = ctrl_reg[0];
   assign sw_route       = ctrl_reg[2:1];

   assign aw_hs = s_axil.awvalid & s_axil.awready;
   assign w_hs  = s_axil.wvalid & s_axil.wready;
   assign ar_hs = s_axil.arvalid & s_axil.arready;

   // A write commits on the edge where its second half arrives, so the
   // live bus value is used for whichever half is not yet held.
   assign wr_commit = (aw_held_reg | aw_hs) & (w_held_reg | w_hs);
   assign wr_idx    = aw_held_reg ? aw_idx_reg : s_axil.awaddr[11:2];
   assign wr_data   = w_held_reg ? wdata_reg : s_axil.wdata;
   assign wr_hit    = (wr_idx <= REG_PKT_CNT);

   assign unused_addr_bits = ^{s_axil.awaddr[31:12], s_axil.awaddr[1:0],
                               s_axil.araddr[31:12], s_axil.araddr[1:0]};

   always_comb begin
      rd_data_next = 32'd0;
      rd_resp_next = RESP_OKAY;
      case (s_axil.araddr[11:2])
         REG_ID:      rd_data_next = ID_VALUE;
         REG_CTRL:    rd_data_next = {29'd0, ctrl_reg};
         REG_SCRATCH: rd_data_next = scratch_reg;
         REG_PKT_CNT: rd_data_next = pkt_cnt_reg;
         default:     rd_resp_next = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rdy_en_reg  <= 1'b0;
         aw_held_reg <= 1'b0;
         aw_idx_reg  <= 10'd0;
         w_held_reg  <= 1'b0;
         wdata_reg   <= 32'd0;
         bvalid_reg  <= 1'b0;
         bresp_reg   <= RESP_OKAY;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= 32'd0;
         rresp_reg   <= RESP_OKAY;
         ctrl_reg    <= 3'd0;
         scratch_reg <= 32'd0;
         pkt_cnt_reg <= 32'd0;
      end else begin
         rdy_en_reg <= 1'b1;

         if (bvalid_reg && s_axil.bready) begin
            bvalid_reg <= 1'b0;
         end
         if (wr_commit) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            if (wr_idx == REG_CTRL) begin
               ctrl_reg <= wr_data[2:0];
            end
            if (wr_idx == REG_SCRATCH) begin
               scratch_reg <= wr_data;
            end
         end else begin
            if (aw_hs) begin
               aw_held_reg <= 1'b1;
               aw_idx_reg  <= s_axil.awaddr[11:2];
            end
            if (w_hs) begin
               w_held_reg <= 1'b1;
               wdata_reg  <= s_axil.wdata;
            end
         end

         // A clear landing together with a packet pulse leaves the count at 0.
         if (wr_commit && wr_idx == REG_PKT_CNT) begin
            pkt_cnt_reg <= 32'd0;
         end else if (pkt_done && ctrl_reg[0]) begin
            pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
         end

         if (rvalid_reg && s_axil.rready) begin
            rvalid_reg <= 1'b0;
         end
         if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data_next;
            rresp_reg  <= rd_resp_next;
         end
      end
   end
endmodule

// File: tb/tb_stream_switch_axil_regs.sv
// Self-checking bench for stream_switch_axil_regs: directed scenarios plus a
// randomized mix of reads, writes and packet pulses against a register model.
module tb_stream_switch_axil_regs;
   localparam logic [31:0] ID = 32'h5357_0001;

   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic       pkt_done = 1'b0;
   logic       sw_enable;
   logic [1:0] sw_route;
   int         total = 0;
   int         passed = 0;

   // Reference model of the programmer-visible state
   logic [2:0]  m_ctrl = 3'd0;
   logic [31:0] m_scratch = 32'd0;
   logic [31:0] m_cnt = 32'd0;

   stream_switch_axil_regs_if axil();

   stream_switch_axil_regs dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .s_axil    (axil),
      .pkt_done  (pkt_done),
      .sw_enable (sw_enable),
      .sw_route  (sw_route)
   );

   always #5 aclk = ~aclk;

   function automatic logic [31:0] model_read(input logic [31:0] addr, output logic [1:0] resp);
      resp = 2'b00;
      case (addr[11:0] & 12'hFFC)
         12'h000: return ID;
         12'h004: return {29'd0, m_ctrl};
         12'h008: return m_scratch;
         12'h00C: return m_cnt;
         default: begin resp = 2'b10; return 32'd0; end
      endcase
   endfunction

   function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data);
      case (addr[11:0] & 12'hFFC)
         12'h000: return 2'b00;
         12'h004: begin m_ctrl = data[2:0]; return 2'b00; end
         12'h008: begin m_scratch = data; return 2'b00; end
         12'h00C: begin m_cnt = 32'd0; return 2'b00; end
         default: return 2'b10;
      endcase
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input int bdelay,
                            output logic [1:0] resp, output bit to, output bit unstable);
      int  n = 0;
      bit  aw_go, w_go;
      to = 0; unstable = 0; resp = 2'b11;
      axil.awaddr = addr; axil.wdata = data;
      axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.bready = 1'b0;
      while ((axil.awvalid || axil.wvalid) && n < 50) begin
         aw_go = axil.awvalid && axil.awready;
         w_go  = axil.wvalid && axil.wready;
         tick(); n++;
         if (aw_go) axil.awvalid = 1'b0;
         if (w_go) axil.wvalid = 1'b0;
      end
      while (!axil.bvalid && n < 50) begin tick(); n++; end
      if (!axil.bvalid) begin
         to = 1; axil.awvalid = 1'b0; axil.wvalid = 1'b0;
         return;
      end
      resp = axil.bresp;
      repeat (bdelay) begin
         tick();
         if (!axil.bvalid || axil.bresp !== resp) unstable = 1;
      end
      axil.bready = 1'b1;
      tick();
      axil.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input int rdelay, output logic [31:0] data,
                           output logic [1:0] resp, output bit to, output bit unstable);
      int n = 0;
      bit ar_go;
      to = 0; unstable = 0; data = 32'hx; resp = 2'b11;
      axil.araddr = addr; axil.arvalid = 1'b1; axil.rready = 1'b0;
      while (axil.arvalid && n < 50) begin
         ar_go = axil.arready;
         tick(); n++;
         if (ar_go) axil.arvalid = 1'b0;
      end
      while (!axil.rvalid && n < 50) begin tick(); n++; end
      if (!axil.rvalid) begin
         to = 1; axil.arvalid = 1'b0;
         return;
      end
      data = axil.rdata; resp = axil.rresp;
      repeat (rdelay) begin
         tick();
         if (!axil.rvalid || axil.rdata !== data || axil.rresp !== resp) unstable = 1;
      end
      axil.rready = 1'b1;
      tick();
      axil.rready = 1'b0;
   endtask

   task automatic pulse(input int count);
      for (int i = 0; i < count; i++) begin
         pkt_done = 1'b1;
         tick();
         pkt_done = 1'b0;
         if (m_ctrl[0]) m_cnt = m_cnt + 32'd1;
         tick();
      end
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r; bit to, us;
      repeat (3) tick();
      total++; if ({axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid, axil.bresp, axil.rresp, axil.rdata, sw_enable, sw_route} !== '0)
         $display("FAIL reset_outputs: got rdy=%b%b%b bv=%b rv=%b rdata=%h en=%b route=%0d, expected all 0", axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid, axil.rdata, sw_enable, sw_route); else passed++;
      aresetn = 1'b1;
      #1;
      total++; if ({axil.awready, axil.wready, axil.arready} !== 3'b000)
         $display("FAIL ready_at_release: got %b expected 000", {axil.awready, axil.wready, axil.arready}); else passed++;
      tick();
      total++; if ({axil.awready, axil.wready, axil.arready} !== 3'b111)
         $display("FAIL ready_after_edge: got %b expected 111", {axil.awready, axil.wready, axil.arready}); else passed++;
      axil.araddr = 32'h0; axil.arvalid = 1'b1;
      tick();
      axil.arvalid = 1'b0;
      total++; if ({axil.rvalid, axil.rresp, axil.rdata} !== {1'b1, 2'b00, ID})
         $display("FAIL read_id_latency: got rvalid=%b rresp=%b rdata=%h expected 1/00/%h", axil.rvalid, axil.rresp, axil.rdata, ID); else passed++;
      axil.rready = 1'b1;
      tick();
      axil.rready = 1'b0;
      total++; if (axil.rvalid !== 1'b0)
         $display("FAIL rvalid_clear: got %b expected 0", axil.rvalid); else passed++;
      axi_read(32'h0, 0, d, r, to, us);
      total++; if (to || d !== ID || r !== 2'b00)
         $display("FAIL read_id: got %h/%b timeout=%0d expected %h/00", d, r, to, ID); else passed++;
   endtask

   task automatic test_write_ctrl();
      bit late;
      axil.awaddr = 32'h4; axil.wdata = 32'h0000_0005;
      axil.awvalid = 1'b1; axil.wvalid = 1'b1;
      tick();
      axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      void'(model_write(32'h4, 32'h5));
      total++; if ({axil.bvalid, axil.bresp, sw_enable, sw_route} !== {1'b1, 2'b00, m_ctrl[0], m_ctrl[2:1]})
         $display("FAIL write_ctrl_same_cycle: got bv=%b bresp=%b en=%b route=%0d expected 1/00/%b/%0d", axil.bvalid, axil.bresp, sw_enable, sw_route, m_ctrl[0], m_ctrl[2:1]); else passed++;
      axil.bready = 1'b1; tick(); axil.bready = 1'b0;
      axil.wdata = 32'h0000_0003; axil.wvalid = 1'b1;
      tick();
      axil.wvalid = 1'b0;
      late = 0;
      repeat (2) begin if (axil.bvalid) late = 1; tick(); end
      if (axil.bvalid) late = 1;
      axil.awaddr = 32'h4; axil.awvalid = 1'b1;
      tick();
      axil.awvalid = 1'b0;
      void'(model_write(32'h4, 32'h3));
      total++; if (late || {axil.bvalid, axil.bresp, sw_enable, sw_route} !== {1'b1, 2'b00, m_ctrl[0], m_ctrl[2:1]})
         $display("FAIL write_ctrl_w_first: got early=%0d bv=%b bresp=%b en=%b route=%0d expected 0/1/00/%b/%0d", late, axil.bvalid, axil.bresp, sw_enable, sw_route, m_ctrl[0], m_ctrl[2:1]); else passed++;
      axil.bready = 1'b1; tick(); axil.bready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] d; logic [1:0] r; bit to, us;
      axil.awaddr = 32'h8; axil.wdata = 32'hDEAD_BEEF;
      axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.bready = 1'b0;
      tick();
      axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      void'(model_write(32'h8, 32'hDEAD_BEEF));
      for (int i = 0; i < 5; i++) begin
         total++; if ({axil.bvalid, axil.awready, axil.wready, axil.bresp} !== 5'b10000)
            $display("FAIL bp_hold_%0d: got bv=%b awr=%b wr=%b bresp=%b expected 1/0/0/00", i, axil.bvalid, axil.awready, axil.wready, axil.bresp); else passed++;
         tick();
      end
      axil.bready = 1'b1; tick(); axil.bready = 1'b0;
      axi_read(32'h8, 2, d, r, to, us);
      total++; if (to || us || d !== m_scratch || r !== 2'b00)
         $display("FAIL bp_readback: got %h/%b to=%0d unstable=%0d expected %h/00", d, r, to, us, m_scratch); else passed++;
   endtask

   task automatic test_counter();
      logic [31:0] d; logic [1:0] r, exp_r; bit to, us;
      axi_write(32'h4, 32'h1, 0, r, to, us); void'(model_write(32'h4, 32'h1));
      pulse(10);
      axi_read(32'hC, 0, d, r, to, us);
      total++; if (to || d !== m_cnt || r !== 2'b00)
         $display("FAIL cnt_ten: got %0d/%b to=%0d expected %0d/00", d, r, to, m_cnt); else passed++;
      axil.awaddr = 32'hC; axil.wdata = $urandom;
      axil.awvalid = 1'b1; axil.wvalid = 1'b1; pkt_done = 1'b1;
      tick();
      axil.awvalid = 1'b0; axil.wvalid = 1'b0; pkt_done = 1'b0;
      exp_r = model_write(32'hC, 32'h0);
      axil.bready = 1'b1; tick(); axil.bready = 1'b0;
      axi_read(32'hC, 0, d, r, to, us);
      total++; if (to || d !== m_cnt || r !== exp_r)
         $display("FAIL cnt_clear_wins: got %0d/%b expected %0d/%b", d, r, m_cnt, exp_r); else passed++;
      axi_write(32'h4, 32'h6, 0, r, to, us); void'(model_write(32'h4, 32'h6));
      pulse(3);
      axi_read(32'hC, 0, d, r, to, us);
      total++; if (to || d !== m_cnt)
         $display("FAIL cnt_disabled: got %0d expected %0d", d, m_cnt); else passed++;
      axi_write(32'h4, 32'h1, 0, r, to, us); void'(model_write(32'h4, 32'h1));
      force dut.pkt_cnt_reg = 32'hFFFF_FFFF;
      #1;
      release dut.pkt_cnt_reg;
      m_cnt = 32'hFFFF_FFFF;
      pulse(1);
      axi_read(32'hC, 0, d, r, to, us);
      total++; if (to || d !== m_cnt)
         $display("FAIL cnt_wrap: got %h expected %h", d, m_cnt); else passed++;
   endtask

   task automatic test_decode_error();
      logic [31:0] d; logic [1:0] r, exp_r; bit to, us;
      axi_read(32'h10, 0, d, r, to, us);
      total++; if (to || d !== 32'd0 || r !== 2'b10)
         $display("FAIL dec_read: got %h/%b expected 0/10", d, r); else passed++;
      exp_r = model_write(32'hFFC, 32'hFFFF_FFFF);
      axi_write(32'hFFC, 32'hFFFF_FFFF, 1, r, to, us);
      total++; if (to || us || r !== exp_r)
         $display("FAIL dec_write: got bresp=%b to=%0d expected %b", r, to, exp_r); else passed++;
      axi_read(32'h8, 0, d, r, to, us);
      total++; if (to || d !== m_scratch || {sw_enable, sw_route} !== {m_ctrl[0], m_ctrl[2:1]})
         $display("FAIL dec_no_effect: got scratch=%h ctrl=%b%0d expected %h %b%0d", d, sw_enable, sw_route, m_scratch, m_ctrl[0], m_ctrl[2:1]); else passed++;
   endtask

   task automatic test_same_cycle_rw();
      logic [31:0] old_v, new_v, d;
      old_v = m_scratch; new_v = $urandom;
      axil.araddr = 32'h8; axil.awaddr = 32'h8; axil.wdata = new_v;
      axil.arvalid = 1'b1; axil.awvalid = 1'b1; axil.wvalid = 1'b1;
      tick();
      axil.arvalid = 1'b0; axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      void'(model_write(32'h8, new_v));
      d = axil.rdata;
      total++; if (!axil.rvalid || !axil.bvalid || d !== old_v)
         $display("FAIL rw_same_edge: got rv=%b bv=%b rdata=%h expected 1/1/%h", axil.rvalid, axil.bvalid, d, old_v); else passed++;
      axil.rready = 1'b1; axil.bready = 1'b1; tick(); axil.rready = 1'b0; axil.bready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int hs = 0;
      axil.araddr = 32'h0; axil.arvalid = 1'b1; axil.rready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (axil.arready) hs++;
         tick();
      end
      axil.arvalid = 1'b0;
      tick();
      axil.rready = 1'b0;
      total++; if (hs !== 3)
         $display("FAIL b2b_reads: got %0d AR handshakes in 6 cycles expected 3", hs); else passed++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic [1:0] r; bit to, us, stray;
      axil.awaddr = 32'h8; axil.awvalid = 1'b1;
      tick();
      axil.awvalid = 1'b0;
      aresetn = 1'b0;
      tick();
      total++; if ({axil.bvalid, axil.awready, axil.wready, axil.arready, sw_enable} !== 5'b0)
         $display("FAIL mid_reset_outputs: got bv=%b rdy=%b%b%b en=%b expected all 0", axil.bvalid, axil.awready, axil.wready, axil.arready, sw_enable); else passed++;
      aresetn = 1'b1;
      m_ctrl = 3'd0; m_scratch = 32'd0; m_cnt = 32'd0;
      tick();
      axil.wdata = 32'h1234_5678; axil.wvalid = 1'b1;
      tick();
      axil.wvalid = 1'b0;
      stray = 0;
      repeat (3) begin if (axil.bvalid) stray = 1; tick(); end
      total++; if (stray)
         $display("FAIL mid_no_stale_aw: got bvalid=1 without a fresh AW expected 0"); else passed++;
      axil.awaddr = 32'h8; axil.awvalid = 1'b1;
      tick();
      axil.awvalid = 1'b0;
      void'(model_write(32'h8, 32'h1234_5678));
      total++; if ({axil.bvalid, axil.bresp} !== 3'b100)
         $display("FAIL mid_next_write: got bv=%b bresp=%b expected 1/00", axil.bvalid, axil.bresp); else passed++;
      axil.bready = 1'b1; tick(); axil.bready = 1'b0;
      axi_read(32'h8, 0, d, r, to, us);
      total++; if (to || d !== m_scratch)
         $display("FAIL mid_readback: got %h expected %h", d, m_scratch); else passed++;
   endtask

   task automatic test_random();
      logic [31:0] a, d, exp_d; logic [1:0] r, exp_r; bit to, us;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 5))
            0: a = 32'h0;
            1: a = 32'h4;
            2: a = 32'h8;
            3: a = 32'hC;
            4: begin a = 32'h0; a[11:2] = 10'($urandom_range(4, 1023)); end
            default: a = $urandom;
         endcase
         a = a | ($urandom & 32'hFFFF_F003);
         case ($urandom_range(0, 2))
            0: begin
               d = $urandom;
               exp_r = model_write(a, d);
               axi_write(a, d, $urandom_range(0, 2), r, to, us);
               total++; if (to || us || r !== exp_r || {sw_enable, sw_route} !== {m_ctrl[0], m_ctrl[2:1]})
                  $display("FAIL rnd_write_%0d: addr=%h got bresp=%b ctrl=%b%0d to=%0d unstable=%0d expected %b %b%0d", i, a, r, sw_enable, sw_route, to, us, exp_r, m_ctrl[0], m_ctrl[2:1]); else passed++;
            end
            1: begin
               exp_d = model_read(a, exp_r);
               axi_read(a, $urandom_range(0, 3), d, r, to, us);
               total++; if (to || us || d !== exp_d || r !== exp_r)
                  $display("FAIL rnd_read_%0d: addr=%h got %h/%b to=%0d unstable=%0d expected %h/%b", i, a, d, r, to, us, exp_d, exp_r); else passed++;
            end
            default: pulse($urandom_range(1, 3));
         endcase
      end
   endtask

   initial begin
      axil.awvalid = 1'b0; axil.awaddr = 32'h0; axil.wvalid = 1'b0; axil.wdata = 32'h0;
      axil.bready = 1'b0; axil.arvalid = 1'b0; axil.araddr = 32'h0; axil.rready = 1'b0;
      test_reset();
      test_write_ctrl();
      test_backpressure();
      test_counter();
      test_decode_error();
      test_same_cycle_rw();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
